// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered syncs, blanking and frame/line pulses.
// Define VGA_TIMING_INTERNAL_DIV_EN to ignore pix_ce and advance on every 4th clk from an internal divider.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       line_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       ce;
  logic       x_wrap;
  logic       y_wrap;
  logic [9:0] x_next;
  logic [9:0] y_next;

`ifdef VGA_TIMING_INTERNAL_DIV_EN
  logic [1:0] div_cnt;
  logic       unused_pix_ce;

  assign unused_pix_ce = pix_ce;

  // Counts 0,1,2,3: the enable fires while the count is 3, i.e. the 4th edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= 2'd0;
    else        div_cnt <= div_cnt + 2'd1;
  end

  assign ce = (div_cnt == 2'd3);
`else
  assign ce = pix_ce;
`endif

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    x_wrap = (x == H_LAST);
    y_wrap = (y == V_LAST);
    x_next = x + 10'd1;
    y_next = y;
    if (x_wrap) begin
      x_next = 10'd0;
      y_next = y_wrap ? 10'd0 : y + 10'd1;
    end
  end

  // Syncs and blanking are decoded from the next position so they line up with x/y on the same edge.
  // NOTE: state uses non-blocking assignments; reset is asynchronous and sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= H_LAST;
      y           <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end else if (ce) begin
      x           <= x_next;
      y           <= y_next;
      hsync       <= !((x_next >= HS_START) && (x_next < HS_END));
      vsync       <= !((y_next >= VS_START) && (y_next < VS_END));
      video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
      frame_start <= x_wrap && y_wrap;
      line_end    <= x_wrap;
    end else begin
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default-timing instance and a small-timing instance share stimulus.
// Expected values come from hand tables and from a position model: p = (enabled edges - 1) mod frame size.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
    logic       line_end;
  } vout_t;

  typedef struct {
    bit    ce;
    int    n;
    vout_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_ce = 1'b0;

  logic       hsync_a, vsync_a, video_on_a, frame_start_a, line_end_a;
  logic [9:0] x_a, y_a;
  logic       hsync_b, vsync_b, video_on_b, frame_start_b, line_end_b;
  logic [9:0] x_b, y_b;
  vout_t      act_a, act_b;

  int compared = 0;
  int mismatched = 0;
  int k = 0;
  bit last_en = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
    .x(x_a), .y(y_a), .frame_start(frame_start_a), .line_end(line_end_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
    .x(x_b), .y(y_b), .frame_start(frame_start_b), .line_end(line_end_b)
  );

  assign act_a = {x_a, y_a, hsync_a, vsync_a, video_on_a, frame_start_a, line_end_a};
  assign act_b = {x_b, y_b, hsync_b, vsync_b, video_on_b, frame_start_b, line_end_b};

  function automatic vout_t mk(int xv, int yv, bit hs, bit vs, bit vo, bit fs, bit le);
    vout_t o;
    o.x = 10'(xv);
    o.y = 10'(yv);
    o.hsync = hs;
    o.vsync = vs;
    o.video_on = vo;
    o.frame_start = fs;
    o.line_end = le;
    return o;
  endfunction

  // kk enabled edges since reset; kk=0 is the reset position (last pixel of the frame).
  function automatic vout_t model(int kk, bit en, int ha, int hfp, int hsw, int hbp,
                                  int va, int vfp, int vsw, int vbp);
    int ht = ha + hfp + hsw + hbp;
    int vt = va + vfp + vsw + vbp;
    int p  = (kk + ht * vt - 1) % (ht * vt);
    int px = p % ht;
    int py = p / ht;
    return mk(px, py,
              !(px >= ha + hfp && px < ha + hfp + hsw),
              !(py >= va + vfp && py < va + vfp + vsw),
              (px < ha) && (py < va),
              en && (p == 0),
              en && (px == 0));
  endfunction

  task automatic check(input string name, input vout_t act, input vout_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b vo=%b fs=%b le=%b, want x=%0d y=%0d hs=%b vs=%b vo=%b fs=%b le=%b",
               name, act.x, act.y, act.hsync, act.vsync, act.video_on, act.frame_start, act.line_end,
               exp.x, exp.y, exp.hsync, exp.vsync, exp.video_on, exp.frame_start, exp.line_end);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_models();
    check("trk_a", act_a, model(k, last_en, 640, 16, 96, 48, 480, 10, 2, 33));
    check("trk_b", act_b, model(k, last_en, 20, 4, 6, 5, 12, 2, 3, 4));
  endtask

  task automatic step(input bit ce);
    @(negedge clk);
    pix_ce = ce;
    @(posedge clk);
    k += int'(ce);
    last_en = ce;
    #1;
    check_models();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pix_ce = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a", act_a, mk(799, 524, 1, 1, 0, 0, 0));
    check("rst_b", act_b, mk(34, 20, 1, 1, 0, 0, 0));
    k = 0;
    last_en = 1'b0;
    rst_n = 1'b1;
  endtask

  vec_t vecs[11];

  initial begin
`ifdef VGA_TIMING_INTERNAL_DIV_EN
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      check("div_a", act_a, mk((e < 4) ? 799 : (e / 4 - 1), (e < 4) ? 524 : 0,
                               1, 1, (e >= 4), (e == 4), (e == 4)));
    end
`else
    int hlow, first_low, first_rise, vlow, lines, frames, fs_cycles;

    vecs[0]  = '{1'b1, 1,   mk(0,   0, 1, 1, 1, 1, 1)};
    vecs[1]  = '{1'b0, 1,   mk(0,   0, 1, 1, 1, 0, 0)};
    vecs[2]  = '{1'b1, 639, mk(639, 0, 1, 1, 1, 0, 0)};
    vecs[3]  = '{1'b1, 1,   mk(640, 0, 1, 1, 0, 0, 0)};
    vecs[4]  = '{1'b1, 15,  mk(655, 0, 1, 1, 0, 0, 0)};
    vecs[5]  = '{1'b1, 1,   mk(656, 0, 0, 1, 0, 0, 0)};
    vecs[6]  = '{1'b0, 3,   mk(656, 0, 0, 1, 0, 0, 0)};
    vecs[7]  = '{1'b1, 95,  mk(751, 0, 0, 1, 0, 0, 0)};
    vecs[8]  = '{1'b1, 1,   mk(752, 0, 1, 1, 0, 0, 0)};
    vecs[9]  = '{1'b1, 47,  mk(799, 0, 1, 1, 0, 0, 0)};
    vecs[10] = '{1'b1, 1,   mk(0,   1, 1, 1, 1, 0, 1)};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      repeat (vecs[i].n) step(vecs[i].ce);
      check($sformatf("vec%0d", i), act_a, vecs[i].exp);
    end

    // One full line at one pixel per clk: hsync low window position and width.
    do_reset();
    hlow = 0; first_low = -1; first_rise = -1;
    for (int i = 0; i < 800; i++) begin
      step(1'b1);
      if (!hsync_a) begin
        hlow++;
        if (first_low < 0) first_low = int'(x_a);
      end else if (first_low >= 0 && first_rise < 0) begin
        first_rise = int'(x_a);
      end
    end
    check_int("hsync_low_clks", hlow, 96);
    check_int("hsync_fall_x", first_low, 656);
    check_int("hsync_rise_x", first_rise, 752);

    // Full frame on the small-timing instance (35 x 21 = 735 clks).
    do_reset();
    vlow = 0; lines = 0; frames = 0;
    for (int i = 0; i < 735; i++) begin
      step(1'b1);
      if (!vsync_b) vlow++;
      if (line_end_b) lines++;
      if (frame_start_b) frames++;
    end
    check_int("vsync_low_clks", vlow, 105);
    check_int("line_end_count", lines, 21);
    check_int("frame_start_count", frames, 1);

    // Enable on 1 of every 4 clks: frame_start lasts one clk, x holds between enables.
    do_reset();
    fs_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      step(i % 4 == 0);
      if (frame_start_a) fs_cycles++;
      if (i == 2) check_int("hold_x", int'(x_a), 0);
    end
    check_int("fs_width", fs_cycles, 1);
    check_int("quarter_x", int'(x_a), 1);

    // Asynchronous reset in the middle of the hsync pulse, checked before the next edge.
    do_reset();
    repeat (701) step(1'b1);
    check("mid_hsync", act_a, mk(700, 0, 0, 1, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    check("async_rst_a", act_a, mk(799, 524, 1, 1, 0, 0, 0));
    check("async_rst_b", act_b, mk(34, 20, 1, 1, 0, 0, 0));

    // Random enable pattern against the position model, spanning several small frames.
    do_reset();
    for (int i = 0; i < 3000; i++) step(($urandom % 3) != 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
